// File: rtl/cp0_exc_ctrl.sv
// CP0 register file and exception/interrupt/ERET sequencer for the 5-stage MIPS pipeline.
// This block is the only writer of Count, Compare, Status, Cause and EPC.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0380,
  parameter int          COUNT_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_hw,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        eret_req,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_cs,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  rd_cs,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EXC_FLUSH  = 2'd1,
    ERET_FLUSH = 2'd2,
    DRAIN      = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic [31:0] epc_r;
  logic [7:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic        bd_r;
  logic        ti_r;
  logic [5:0]  ip_hw_r;
  logic [1:0]  ip_sw_r;
  logic [4:0]  exccode_r;
  logic        div_r;
  logic        flush_r;
  logic        stall_r;
  logic        redirect_valid_r;
  logic [31:0] redirect_pc_r;

  logic [31:0] status_s;
  logic [31:0] cause_s;
  logic        int_pending_s;
  logic        take_exc_s;
  logic        take_eret_s;
  logic        take_mtc0_s;
  logic        wr_count_s;
  logic        wr_compare_s;
  logic        tick_s;
  logic [31:0] count_next_s;
  logic        ti_next_s;
  logic [31:0] epc_entry_s;

  // Register views, request arbitration and next Count/TI values
  always_comb begin
    status_s      = {16'd0, im_r, 6'd0, exl_r, ie_r};
    cause_s       = {bd_r, ti_r, 14'd0, ip_hw_r, ip_sw_r, 1'b0, exccode_r, 2'd0};
    int_pending_s = ie_r & ~exl_r & (|(cause_s[15:8] & im_r)) & mem_valid;
    take_exc_s    = (state_r == IDLE) & (exc_req | int_pending_s);
    take_eret_s   = (state_r == IDLE) & ~take_exc_s & eret_req;
    take_mtc0_s   = (state_r == IDLE) & ~take_exc_s & ~eret_req & mtc0_we;
    wr_count_s    = take_mtc0_s & (mtc0_cs == 5'd9)  & (mtc0_sel == 3'd0);
    wr_compare_s  = take_mtc0_s & (mtc0_cs == 5'd11) & (mtc0_sel == 3'd0);
    tick_s        = (COUNT_DIV == 1) | div_r;
    epc_entry_s   = mem_bd ? (mem_pc - 32'd4) : mem_pc;
    if (wr_count_s) begin
      count_next_s = mtc0_wdata;
    end else if (tick_s) begin
      count_next_s = count_r + 32'd1;
    end else begin
      count_next_s = count_r;
    end
    // A Compare write always wins over a simultaneous match
    if (wr_compare_s) begin
      ti_next_s = 1'b0;
    end else if (count_next_s == compare_r) begin
      ti_next_s = 1'b1;
    end else begin
      ti_next_s = ti_r;
    end
  end

  // MFC0 read mux, showing state before this cycle's write
  always_comb begin
    rd_data = 32'd0;
    if (rd_sel == 3'd0) begin
      case (rd_cs)
        5'd9:    rd_data = count_r;
        5'd11:   rd_data = compare_r;
        5'd12:   rd_data = status_s;
        5'd13:   rd_data = cause_s;
        5'd14:   rd_data = epc_r;
        default: rd_data = 32'd0;
      endcase
    end else begin
      rd_data = 32'd0;
    end
  end

  // Sequencer state and registered pipeline control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= IDLE;
      flush_r          <= 1'b0;
      stall_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (take_exc_s) begin
            state_r          <= EXC_FLUSH;
            flush_r          <= 1'b1;
            stall_r          <= 1'b1;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= EXC_VECTOR;
          end else if (take_eret_s) begin
            state_r          <= ERET_FLUSH;
            flush_r          <= 1'b1;
            stall_r          <= 1'b1;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= epc_r;
          end else begin
            state_r          <= IDLE;
            flush_r          <= 1'b0;
            stall_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
          end
        end
        EXC_FLUSH, ERET_FLUSH: begin
          state_r          <= DRAIN;
          flush_r          <= 1'b0;
          stall_r          <= 1'b0;
          redirect_valid_r <= 1'b0;
          redirect_pc_r    <= 32'd0;
        end
        DRAIN: begin
          state_r          <= IDLE;
          flush_r          <= 1'b0;
          stall_r          <= 1'b0;
          redirect_valid_r <= 1'b0;
          redirect_pc_r    <= 32'd0;
        end
        default: begin
          state_r          <= IDLE;
          flush_r          <= 1'b0;
          stall_r          <= 1'b0;
          redirect_valid_r <= 1'b0;
          redirect_pc_r    <= 32'd0;
        end
      endcase
    end
  end

  // CP0 architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= 32'd0;
      compare_r <= 32'd0;
      epc_r     <= 32'd0;
      im_r      <= 8'd0;
      exl_r     <= 1'b0;
      ie_r      <= 1'b0;
      bd_r      <= 1'b0;
      ti_r      <= 1'b0;
      ip_hw_r   <= 6'd0;
      ip_sw_r   <= 2'd0;
      exccode_r <= 5'd0;
      div_r     <= 1'b0;
    end else begin
      count_r <= count_next_s;
      div_r   <= wr_count_s ? 1'b0 : ~div_r;
      ti_r    <= ti_next_s;
      ip_hw_r <= {int_hw[5] | ti_next_s, int_hw[4:0]};
      if (wr_compare_s) begin
        compare_r <= mtc0_wdata;
      end
      if (take_exc_s) begin
        // A nested exception keeps the original return point
        if (!exl_r) begin
          epc_r <= epc_entry_s;
          bd_r  <= mem_bd;
        end
        exccode_r <= exc_req ? exc_code : 5'd0;
        exl_r     <= 1'b1;
      end else if (take_eret_s) begin
        exl_r <= 1'b0;
      end else if (take_mtc0_s && (mtc0_sel == 3'd0)) begin
        case (mtc0_cs)
          5'd12: begin
            im_r  <= mtc0_wdata[15:8];
            exl_r <= mtc0_wdata[1];
            ie_r  <= mtc0_wdata[0];
          end
          5'd13:   ip_sw_r <= mtc0_wdata[9:8];
          5'd14:   epc_r   <= mtc0_wdata;
          default: ;
        endcase
      end
    end
  end

  assign flush          = flush_r;
  assign stall          = stall_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign status_o       = status_s;
  assign cause_o        = cause_s;
  assign epc_o          = epc_r;

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Owns the CP0 register set (Count, Compare, Status, Cause, EPC) and sequences exception entry, interrupt entry and ERET return for the 5-stage MIPS pipeline.
- Sits beside the MEM stage. Accepts exception, ERET and MTC0 requests from MEM, serves MFC0 reads to ID, and drives the pipeline flush, stall and PC redirect.
- The CP0 forwarding unit covers hazards on the read data; this block is the single writer of CP0 state.

Parameters:
- EXC_VECTOR, 32'h0000_0380, PC loaded on exception or interrupt entry.
- COUNT_DIV, 1, Count increments once every COUNT_DIV cycles; legal values are 1 or 2.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous reset, active-high.
- int_hw  in  6  external interrupt lines, level-sensitive, map to Cause.IP[7:2]; IP[7] is ORed with the timer.
- mem_valid  in  1  a real instruction is present in MEM.
- mem_pc  in  32  PC of the MEM instruction.
- mem_bd  in  1  MEM instruction is in a branch delay slot.
- exc_req  in  1  MEM instruction raised a synchronous exception.
- exc_code  in  5  ExcCode for exc_req.
- eret_req  in  1  MEM instruction is ERET.
- mtc0_we  in  1  MEM instruction is MTC0.
- mtc0_cs  in  5  target register number.
- mtc0_sel  in  3  target sel.
- mtc0_wdata  in  32  write data.
- rd_cs  in  5  MFC0 read register number.
- rd_sel  in  3  MFC0 read sel.
- rd_data  out  32  combinational read data; 0 for unimplemented registers.
- flush  out  1  kill IF, ID, EX and MEM.
- stall  out  1  hold PC and IF/ID.
- redirect_valid  out  1  load redirect_pc into PC.
- redirect_pc  out  32  target PC.
- status_o, cause_o, epc_o  out  32 each  current register values.

Behaviour:
- Registers implemented: Count (9,0), Compare (11,0), Status (12,0), Cause (13,0), EPC (14,0).
- Status writable bits: IM[15:8], EXL[1], IE[0]. All others read 0.
- Cause fields: BD[31], TI[30], IP[15:8], ExcCode[6:2]. Only IP[1:0] is software-writable via MTC0.
- Reset (async): all registers 0, state IDLE, all outputs 0.
- Cause.IP[7:2] is refreshed every cycle from {int_hw[5] | TI, int_hw[4:0]}.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM) & mem_valid.
- State machine: IDLE, EXC_FLUSH, ERET_FLUSH, DRAIN.
- IDLE priority, highest first: exc_req, int_pending, eret_req, mtc0_we.
  - Exception or interrupt accepted: at the next edge,
    - EPC = mem_bd ? mem_pc-4 : mem_pc
    - Cause.BD = mem_bd
    - Cause.ExcCode = exc_req ? exc_code : 0
    - Status.EXL = 1
    - state -> EXC_FLUSH
    - any MTC0 in the same cycle is dropped.
  - If Status.EXL=1 when exc_req arrives, EPC and BD are NOT updated; ExcCode is still updated and the sequence still runs.
  - eret_req: Status.EXL cleared at the next edge; state -> ERET_FLUSH.
  - mtc0_we alone: register written at the next edge; no state change.
- EXC_FLUSH (one cycle): flush=1, stall=1, redirect_valid=1, redirect_pc=EXC_VECTOR; -> DRAIN.
- ERET_FLUSH (one cycle): flush=1, stall=1, redirect_valid=1, redirect_pc=EPC; -> DRAIN.
- DRAIN (one cycle): all control outputs 0; requests ignored; -> IDLE.
- Requests and interrupts are ignored in every non-IDLE state.
- Latency: request accepted in cycle T -> redirect in T+1 -> new requests accepted from T+3.
- Count:
  - Increments (mod 2^32, wraps silently) every COUNT_DIV cycles.
  - MTC0 to Count overrides the increment that cycle and restarts the divider phase.
- Timer:
  - When Count == Compare after the update (and Compare was not written that cycle), TI is set.
  - MTC0 to Compare clears TI. A write and a match in the same cycle leave TI=0.
- rd_data reflects register state before the current cycle's write; no internal bypass.
- Reset asserted mid-sequence returns to IDLE with outputs 0 immediately.

Test Plan:
- Reset, then MTC0 Status=32'h0000_FF01, then MFC0 (12,0) -> rd_data=32'h0000_FF01; flush stays 0.
- IDLE, exc_req=1, exc_code=5'd12, mem_pc=32'h0000_1000, mem_bd=0 -> next cycle: flush=1, redirect_pc=32'h380, EPC=32'h1000, Cause[6:2]=12, Status.EXL=1. Two cycles later the state is IDLE.
- Same as the previous case with mem_bd=1, mem_pc=32'h2004 -> EPC=32'h2000, Cause.BD=1. A following ERET -> redirect_pc=32'h2000, EXL=0.
- Status IE=1, IM[2]=1; raise int_hw[0] with mem_valid=1 -> one exception entry with ExcCode 0. Holding int_hw[0] through DRAIN causes no re-entry while EXL=1.
- Compare=10, Count=8 (COUNT_DIV=1) -> TI and Cause.IP[7] set two cycles later. MTC0 Compare=100 -> TI=0.
- exc_req and mtc0_we (EPC=32'hDEAD) in the same cycle -> EPC holds the exception value; the MTC0 is dropped.
